// File: rtl/redop_frame_checker.sv
// -----------------------------------------------------------------------------
// redop_frame_checker
//
// Streaming receiver for a reduction/parity-protected word stream. Across every
// bit of a multi-word frame it evaluates AND, OR and XOR (plus their
// complements). It also checks the sender's per-word even parity. One
// registered result record is returned per frame over a valid/ready handshake.
// While that record is pending, the input is backpressured.
//
// Parameters
//   WIDTH   data word width in bits (>= 2)
//   MAXLEN  maximum words per frame; reaching it force-terminates the frame
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  input beat handshake
//   in_data, in_par    data word and its even-parity bit
//   in_last            final word of the frame
//   res_valid/res_ready  result record handshake
//   res_and/or/xor     reductions over all frame bits
//   res_nand/nor/xnor  complements of the above
//   res_perr           at least one word of the frame failed parity
//   res_ovf            frame was cut at MAXLEN without in_last
//   res_len            words in the frame
//   err_cnt            saturating count of bad-parity words since reset
//
// Build option
//   REDOP_ERRCNT_EN    when defined, err_cnt is implemented; otherwise it is
//                      tied to 0 (res_perr is unaffected)
// -----------------------------------------------------------------------------
module redop_frame_checker #(
   parameter  int WIDTH  = 8,
   parameter  int MAXLEN = 16,
   localparam int LW     = $clog2(MAXLEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_par,
   input  logic             in_last,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_and,
   output logic             res_or,
   output logic             res_xor,
   output logic             res_nand,
   output logic             res_nor,
   output logic             res_xnor,
   output logic             res_perr,
   output logic             res_ovf,
   output logic [LW-1:0]    res_len,
   output logic [15:0]      err_cnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_RES  = 2'd2;

   logic [1:0]    r_state;
   logic          r_and_acc, r_or_acc, r_xor_acc, r_perr_acc;
   logic [LW-1:0] r_len;

   logic          r_res_and, r_res_or, r_res_xor;
   logic          r_res_nand, r_res_nor, r_res_xnor;
   logic          r_res_perr, r_res_ovf;
   logic [LW-1:0] r_res_len;

   logic          w_accept, w_first, w_at_max, w_term;
   logic          w_word_and, w_word_or, w_word_xor, w_word_perr;
   logic          w_and_nxt, w_or_nxt, w_xor_nxt, w_perr_nxt;
   logic [LW-1:0] w_len_nxt;

   assign in_ready  = (r_state != S_RES);
   assign res_valid = (r_state == S_RES);
   assign w_accept  = in_valid && in_ready;
   assign w_first   = (r_state == S_IDLE);

   // Per-word reductions; a word with odd {data,par} weight fails parity.
   assign w_word_and  = &in_data;
   assign w_word_or   = |in_data;
   assign w_word_xor  = ^in_data;
   assign w_word_perr = ^{in_data, in_par};

   // The first beat loads the accumulators instead of combining with stale
   // values left over from the previous frame.
   assign w_and_nxt  = w_first ? w_word_and  : (r_and_acc  & w_word_and);
   assign w_or_nxt   = w_first ? w_word_or   : (r_or_acc   | w_word_or);
   assign w_xor_nxt  = w_first ? w_word_xor  : (r_xor_acc  ^ w_word_xor);
   assign w_perr_nxt = w_first ? w_word_perr : (r_perr_acc | w_word_perr);
   assign w_len_nxt  = w_first ? LW'(1) : (r_len + LW'(1));

   // The length check uses the post-increment count. This lets the MAXLEN-th
   // beat end the frame on the same edge that accepts it.
   assign w_at_max = (w_len_nxt == LW'(MAXLEN));
   assign w_term   = w_accept && (in_last || w_at_max);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_and_acc  <= 1'b0;
         r_or_acc   <= 1'b0;
         r_xor_acc  <= 1'b0;
         r_perr_acc <= 1'b0;
         r_len      <= '0;
         r_res_and  <= 1'b0;
         r_res_or   <= 1'b0;
         r_res_xor  <= 1'b0;
         r_res_nand <= 1'b0;
         r_res_nor  <= 1'b0;
         r_res_xnor <= 1'b0;
         r_res_perr <= 1'b0;
         r_res_ovf  <= 1'b0;
         r_res_len  <= '0;
      end else begin
         if (w_accept) begin
            r_and_acc  <= w_and_nxt;
            r_or_acc   <= w_or_nxt;
            r_xor_acc  <= w_xor_nxt;
            r_perr_acc <= w_perr_nxt;
            r_len      <= w_len_nxt;
         end

         case (r_state)
            S_IDLE, S_ACC: if (w_accept) r_state <= w_term ? S_RES : S_ACC;
            S_RES:         if (res_ready) r_state <= S_IDLE;
            default:       r_state <= S_IDLE;
         endcase

         // The record stays loaded after the handshake. It is only replaced
         // when the next frame terminates.
         if (w_term) begin
            r_res_and  <= w_and_nxt;
            r_res_or   <= w_or_nxt;
            r_res_xor  <= w_xor_nxt;
            r_res_nand <= ~w_and_nxt;
            r_res_nor  <= ~w_or_nxt;
            r_res_xnor <= ~w_xor_nxt;
            r_res_perr <= w_perr_nxt;
            r_res_ovf  <= w_at_max && !in_last;
            r_res_len  <= w_len_nxt;
         end
      end
   end

   assign res_and  = r_res_and;
   assign res_or   = r_res_or;
   assign res_xor  = r_res_xor;
   assign res_nand = r_res_nand;
   assign res_nor  = r_res_nor;
   assign res_xnor = r_res_xnor;
   assign res_perr = r_res_perr;
   assign res_ovf  = r_res_ovf;
   assign res_len  = r_res_len;

`ifdef REDOP_ERRCNT_EN
   logic [15:0] r_err_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_err_cnt <= '0;
      else if (w_accept && w_word_perr && (r_err_cnt != 16'hFFFF))
         r_err_cnt <= r_err_cnt + 16'd1;
   end

   assign err_cnt = r_err_cnt;
`else
   assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_redop_frame_checker.sv
module tb_redop_frame_checker;
   localparam int W  = 8;
   localparam int M  = 16;
   localparam int LW = $clog2(M + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0, in_par = 1'b0, in_last = 1'b0, res_ready = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_ready, res_valid;
   logic          res_and, res_or, res_xor, res_nand, res_nor, res_xnor, res_perr, res_ovf;
   logic [LW-1:0] res_len;
   logic [15:0]   err_cnt;

   redop_frame_checker #(.WIDTH(W), .MAXLEN(M)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_par(in_par), .in_last(in_last),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_and(res_and), .res_or(res_or), .res_xor(res_xor),
      .res_nand(res_nand), .res_nor(res_nor), .res_xnor(res_xnor),
      .res_perr(res_perr), .res_ovf(res_ovf), .res_len(res_len),
      .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: words of the open frame and the resulting record.
   logic [W-1:0] q_d[$];
   logic         q_p[$];
   int           exp_err = 0;
   bit           e_and, e_or, e_xor, e_perr, e_ovf;
   int           e_len;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // The whole frame is treated as one bit vector, summarized by its ones count.
   task automatic close_frame(input bit last);
      int ones;
      ones   = 0;
      e_perr = 0;
      foreach (q_d[i]) begin
         ones += $countones(q_d[i]);
         if ($countones({q_d[i], q_p[i]}) % 2 == 1) e_perr = 1;
      end
      e_len = q_d.size();
      e_and = (ones == e_len * W);
      e_or  = (ones != 0);
      e_xor = (ones % 2 == 1);
      e_ovf = (e_len == M) && !last;
      q_d.delete();
      q_p.delete();
   endtask

   task automatic check_rec(input string tag, input bit vexp);
      chk({tag, ".valid"}, res_valid, vexp);
      chk({tag, ".flags"},
          {res_and, res_or, res_xor, res_nand, res_nor, res_xnor, res_perr, res_ovf},
          {e_and, e_or, e_xor, ~e_and, ~e_or, ~e_xor, e_perr, e_ovf});
      chk({tag, ".len"}, res_len, e_len);
   endtask

   task automatic check_err(input string tag);
`ifdef REDOP_ERRCNT_EN
      chk(tag, err_cnt, exp_err);
`else
      chk(tag, err_cnt, 0);
`endif
   endtask

   task automatic reset_check(input string tag);
      chk({tag, ".valid"}, res_valid, 0);
      chk({tag, ".ready"}, in_ready, 1);
      chk({tag, ".flags"},
          {res_and, res_or, res_xor, res_nand, res_nor, res_xnor, res_perr, res_ovf}, 0);
      chk({tag, ".len"}, res_len, 0);
      chk({tag, ".err"}, err_cnt, 0);
   endtask

   task automatic junk_inputs(input bit v);
      in_valid = v;
      in_data  = W'($urandom);
      in_par   = 1'($urandom);
      in_last  = 1'($urandom);
   endtask

   // One accepted beat. A terminating beat has its record checked, is held
   // for 'hold' cycles under junk traffic, and is then consumed.
   task automatic beat(input logic [W-1:0] d, input logic p, input logic l, input int hold);
      chk("in_ready", in_ready, 1);
      in_valid = 1'b1; in_data = d; in_par = p; in_last = l;
      tick();
      junk_inputs(1'b0);
      q_d.push_back(d);
      q_p.push_back(p);
      if (($countones({d, p}) % 2 == 1) && exp_err < 65535) exp_err++;
      check_err("err_cnt");
      if (l || q_d.size() == M) begin
         close_frame(l);
         check_rec("rec", 1'b1);
         for (int h = 0; h < hold; h++) begin
            junk_inputs(1'b1);
            tick();
            chk("hold.ready", in_ready, 0);
            check_rec("hold", 1'b1);
         end
         junk_inputs(1'b1);
         res_ready = 1'b1;
         tick();
         res_ready = 1'b0;
         junk_inputs(1'b0);
         chk("after.ready", in_ready, 1);
         check_rec("after", 1'b0);
         check_err("err_keep");
      end else begin
         chk("rv_low", res_valid, 0);
      end
   endtask

   initial begin
      #12;
      reset_check("reset");
      rst_n = 1'b1;
      tick();

      // All-ones two-word frame.
      beat(8'hFF, 1'b0, 1'b0, 0);
      beat(8'hFF, 1'b0, 1'b1, 0);
      // Single all-zero word.
      beat(8'h00, 1'b0, 1'b1, 0);
      // Parity error on the first word.
      beat(8'h01, 1'b0, 1'b0, 0);
      beat(8'h03, 1'b0, 1'b1, 0);
      // Long backpressure hold.
      beat(8'h5A, 1'b0, 1'b1, 5);
      // MAXLEN overflow; the following beat opens a fresh frame.
      repeat (M) beat(8'hA5, 1'b0, 1'b0, 0);
      beat(8'h3C, 1'b0, 1'b1, 0);
      // Exactly MAXLEN words with last on the final one: not an overflow.
      for (int i = 0; i < M; i++) beat(8'hC3, 1'b0, (i == M - 1), 1);

      // Reset mid-frame discards everything.
      beat(8'h11, 1'b0, 1'b0, 0);
      beat(8'h12, 1'b1, 1'b0, 0);
      beat(8'h13, 1'b1, 1'b0, 0);
      rst_n = 1'b0;
      #1;
      reset_check("midrst");
      q_d.delete();
      q_p.delete();
      exp_err = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      beat(8'h77, 1'b0, 1'b1, 0);

      // Random frames, occasionally longer than MAXLEN, with idle gaps and bad parity.
      for (int f = 0; f < 200; f++) begin
         int len;
         len = $urandom_range(1, M + 2);
         for (int i = 0; i < len; i++) begin
            logic [W-1:0] d;
            logic         p;
            if ($urandom_range(0, 3) == 0) begin
               junk_inputs(1'b0);
               tick();
               chk("idle.rv", res_valid, 0);
            end
            d = W'($urandom);
            p = ($urandom_range(0, 4) == 0) ? ~(^d) : ^d;
            beat(d, p, (i == len - 1), $urandom_range(0, 3));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/redop_frame_checker.md
# redop_frame_checker

Streaming receiver that evaluates the six reduction operators (AND, OR, NAND, NOR, XOR, XNOR) across every bit of a multi-word frame and checks the per-word even parity supplied by the sender. It is the consuming end of a reduction/parity-protected word stream, placed after the link that produces per-word parity bits. It returns one registered result record per frame through a valid/ready handshake and exerts backpressure while that record is pending.

## Interface
- WIDTH, 8: data word width in bits (≥2).
- MAXLEN, 16: maximum words per frame; a frame that reaches this length is force-terminated.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  WIDTH  data word.
- in_par  input  1  sender's even-parity bit; correct when ^{in_data,in_par}==0.
- in_last  input  1  final word of the frame.
- res_valid  output  1  result record valid.
- res_ready  input  1  consumer accepts the record.
- res_and, res_or, res_xor  output  1 each  reductions over all frame bits.
- res_nand, res_nor, res_xnor  output  1 each  complements of the three above.
- res_perr  output  1  at least one word in the frame failed parity.
- res_ovf  output  1  frame was terminated at MAXLEN without in_last.
- res_len  output  $clog2(MAXLEN+1)  number of words in the frame.
- err_cnt  output  16  running count of failed-parity words since reset.

## Operation
- Beat accepted when in_valid && in_ready. in_ready = (state != RES).
- FSM states: IDLE (no frame open), ACC (frame open), RES (record held).
  - IDLE + accepted beat, in_last=0 → ACC; in_last=1 → RES.
  - ACC + accepted beat, in_last=1 or word count reaches MAXLEN → RES; otherwise stay in ACC.
  - RES + res_ready → IDLE.
- Accumulators are loaded on the first beat and updated on each later beat: and_acc &= &in_data; or_acc |= |in_data; xor_acc ^= ^in_data; perr_acc |= ^{in_data,in_par}; len increments.
- On entry to RES the record registers are loaded: res_nand=~res_and, res_nor=~res_or, res_xnor=~res_xor. res_ovf=1 only when the MAXLEN-th beat arrives with in_last=0. A MAXLEN-th beat that carries in_last=1 gives res_ovf=0.
- err_cnt increments once per accepted beat with bad parity and saturates at 16'hFFFF. It is not cleared between frames.
- Record outputs hold stable while res_valid=1 and retain their values after the handshake until the next frame result is loaded.

## Timing
- Reset: state=IDLE (in_ready=1 immediately), res_valid=0, all res_* outputs 0, res_len=0, err_cnt=0, accumulators 0.
- Latency: res_valid rises on the clock edge that accepts the terminating beat and is visible the cycle after that beat.
- The record is held until res_ready=1 is sampled with res_valid=1. res_valid falls on that edge and in_ready returns to 1 in the same following cycle.
- No beat can be accepted in the cycle of the res handshake, since in_ready=0 in RES. Minimum frame period is therefore length+1 cycles.
- Asserting rst_n low mid-frame or while RES is held discards the frame and record asynchronously. No partial record is emitted.
- in_data, in_par and in_last are ignored when the beat is not accepted.

## Configuration
- REDOP_ERRCNT_EN: when defined, err_cnt is implemented as described.
- When REDOP_ERRCNT_EN is not defined, the counter logic is removed and err_cnt is driven constant 0. res_perr is unaffected either way.

## Test plan
- WIDTH=8. Frame 8'hFF/par0, 8'hFF/par0/last, res_ready=1 → one cycle later res_and=1, res_or=1, res_xor=0, res_nand=0, res_nor=0, res_xnor=1, res_perr=0, res_len=2.
- Single word 8'h00/par0/last → res_and=0, res_or=0, res_xor=0, res_nand=1, res_nor=1, res_xnor=1, res_len=1, res_ovf=0.
- Frame 8'h01/par0, 8'h03/par0/last → res_xor=1, res_perr=1, err_cnt=1 (0 when REDOP_ERRCNT_EN is undefined).
- Hold res_ready=0 for 5 cycles after a result → res_valid and all outputs stable, in_ready=0, in_valid ignored. Raising res_ready gives res_valid=0 and in_ready=1 the next cycle.
- MAXLEN=16: 16 beats of 8'hA5/par0 without last → res_ovf=1, res_len=16, res_xor=0, res_and=0, res_or=1. The 17th beat opens a new frame.
- Drop rst_n for 1 cycle after 3 beats of a frame → all outputs reset, and a following 1-word frame reports res_len=1.
